// File: rtl/alu_operand_loader_if.sv
// rtl/alu_operand_loader_if.sv - ALU-side bus of alu_operand_loader: operands, opcode, result, stage.
interface alu_operand_loader_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] Op;
  logic [3:0] alu_r;
  logic [3:0] result;
  logic       result_valid;
  logic [1:0] stage;

  modport master (
    output A, B, Op, result, result_valid, stage,
    input  alu_r
  );

  modport slave (
    input  A, B, Op, result, result_valid, stage,
    output alu_r
  );
endinterface

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - switch/Enter operand sequencer for the 4-bit board ALU.
// Optional button debounce is built when DEBOUNCE_EN is defined.
module alu_operand_loader #(
  parameter int DB_CYCLES = 250000,
  parameter int SYNC_FF   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  sw_i,
  input  logic                        btn_enter_i,
  input  logic                        btn_clear_i,
  alu_operand_loader_if.master        bus
);

  if (SYNC_FF < 2 || DB_CYCLES < 2) begin : g_param_check
    $error("alu_operand_loader: SYNC_FF and DB_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    SHOW    = 2'b11
  } stage_e;

  logic [3:0]         sw_sync_q [SYNC_FF];
  logic [SYNC_FF-1:0] ent_sync_q;
  logic [SYNC_FF-1:0] clr_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_FF; i++) sw_sync_q[i] <= '0;
      ent_sync_q <= '0;
      clr_sync_q <= '0;
    end else begin
      sw_sync_q[0] <= sw_i;
      for (int i = 1; i < SYNC_FF; i++) sw_sync_q[i] <= sw_sync_q[i-1];
      ent_sync_q <= {ent_sync_q[SYNC_FF-2:0], btn_enter_i};
      clr_sync_q <= {clr_sync_q[SYNC_FF-2:0], btn_clear_i};
    end
  end

  logic [3:0] sw_s;
  logic       ent_s;
  logic       clr_s;
  logic       ent_lvl;
  logic       clr_lvl;

  assign sw_s  = sw_sync_q[SYNC_FF-1];
  assign ent_s = ent_sync_q[SYNC_FF-1];
  assign clr_s = clr_sync_q[SYNC_FF-1];

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] ent_cnt_q;
  logic [CNT_W-1:0] clr_cnt_q;
  logic             ent_db_q;
  logic             clr_db_q;

  // Counter measures how long the synchronised level has disagreed with the debounced one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_cnt_q <= '0;
      clr_cnt_q <= '0;
      ent_db_q  <= 1'b0;
      clr_db_q  <= 1'b0;
    end else begin
      if (ent_s == ent_db_q) begin
        ent_cnt_q <= '0;
      end else if (ent_cnt_q == CNT_LAST) begin
        ent_db_q  <= ent_s;
        ent_cnt_q <= '0;
      end else begin
        ent_cnt_q <= ent_cnt_q + 1'b1;
      end
      if (clr_s == clr_db_q) begin
        clr_cnt_q <= '0;
      end else if (clr_cnt_q == CNT_LAST) begin
        clr_db_q  <= clr_s;
        clr_cnt_q <= '0;
      end else begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

  assign ent_lvl = ent_db_q;
  assign clr_lvl = clr_db_q;
`else
  assign ent_lvl = ent_s;
  assign clr_lvl = clr_s;
`endif

  logic ent_prev_q;
  logic clr_prev_q;
  logic enter_p;
  logic clear_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      ent_prev_q <= ent_lvl;
      clr_prev_q <= clr_lvl;
    end
  end

  assign enter_p = ent_lvl & ~ent_prev_q;
  assign clear_p = clr_lvl & ~clr_prev_q;

  stage_e     stage_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic [3:0] result_q;
  logic       valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (clear_p) begin
      stage_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (enter_p) begin
      case (stage_q)
        LOAD_A:  begin a_q  <= sw_s;      stage_q <= LOAD_B;  end
        LOAD_B:  begin b_q  <= sw_s;      stage_q <= LOAD_OP; end
        LOAD_OP: begin op_q <= sw_s[1:0]; stage_q <= SHOW;    end
        default: begin valid_q <= 1'b0;   stage_q <= LOAD_A;  end
      endcase
    end else if (stage_q == SHOW) begin
      // alu_r already reflects the captured Op on the first SHOW edge.
      result_q <= bus.alu_r;
      valid_q  <= 1'b1;
    end
  end

  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.Op           = op_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.stage        = stage_q;

endmodule
